bist_seq_ctrl: RTL and testbench

Parametrised BIST sequencer for the JTAG test logic. Runs a programmable number of patterns against the circuit under test and sequences apply, settle, capture and compare for each one. Compacts responses into a MISR signature and logs error count and first failing pattern. It sits between the TAP instruction decoder (`Mode_sel`/`start`) and the pattern generator and capture logic, and exports a 5-bit `BIST_CODE` for the TDR status chain.

---
 rtl/bist_pkg.sv | 30 +++
 rtl/bist_misr.sv | 37 +++
 rtl/bist_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_bist_seq_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: state encoding and run-mode codes.
package bist_pkg;

  // State values double as the exported BIST_CODE.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StApply   = 3'd2,
    StSettle  = 3'd3,
    StCapture = 3'd4,
    StCheck   = 3'd5,
    StFinish  = 3'd6,
    StDone    = 3'd7
  } bist_state_e;

  localparam logic [3:0] ModeBypass  = 4'b0000;
  localparam logic [3:0] ModeFull    = 4'b0100;
  localparam logic [3:0] ModeStopErr = 4'b0101;
  localparam logic [3:0] ModeSig     = 4'b0110;

  // Modes that actually sequence patterns; everything else ends immediately.
  function automatic logic mode_runs(logic [3:0] mode);
    return (mode == ModeFull) || (mode == ModeStopErr) || (mode == ModeSig);
  endfunction

  function automatic logic [4:0] bist_code(bist_state_e st);
    return {2'b00, st};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting captured CUT responses.
module bist_misr #(
  parameter int unsigned          DATA_W    = 16,
  parameter logic [DATA_W-1:0]    MISR_POLY = DATA_W'('h1021)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              seed,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sig
);

  logic [DATA_W-1:0] sig_d, sig_q;

  // Next signature: seed to all ones, or shift/feedback/fold-in one response.
  always_comb begin
    sig_d = sig_q;
    if (seed) begin
      sig_d = '1;
    end else if (en) begin
      sig_d = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? MISR_POLY : '0) ^ din;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (res) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: runs apply/settle/capture/check per pattern, compacts responses
// into a MISR and reports error count, first failing pattern and pass/fail.
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned       PAT_W     = 8,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       SETTLE    = 2,
  parameter logic [DATA_W-1:0] MISR_POLY = DATA_W'('h1021)
) (
  input  logic              BIST_clk,
  input  logic              res,
  input  logic [3:0]        Mode_sel,
  input  logic              start,
  input  logic              abort,
  input  logic [PAT_W-1:0]  pat_limit,
  input  logic [DATA_W-1:0] resp_in,
  input  logic [DATA_W-1:0] expect_in,
  output logic              pat_en,
  output logic              cap_en,
  output logic [PAT_W-1:0]  pat_idx,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [PAT_W:0]    err_cnt,
  output logic [PAT_W-1:0]  first_err,
  output logic [DATA_W-1:0] signature,
  output logic [4:0]        BIST_CODE
);

  localparam int unsigned     CntW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);

  bist_state_e       state_d, state_q;
  logic [3:0]        mode_d, mode_q;
  logic [PAT_W-1:0]  limit_d, limit_q;
  logic [PAT_W-1:0]  pat_idx_d, pat_idx_q;
  logic [PAT_W:0]    err_cnt_d, err_cnt_q;
  logic [PAT_W-1:0]  first_err_d, first_err_q;
  logic              pass_d, pass_q;
  logic              aborted_d, aborted_q;
  logic [DATA_W-1:0] cap_d, cap_q;
  logic [CntW-1:0]   settle_cnt_d, settle_cnt_q;
  logic              misr_seed, misr_en, mismatch, busy_w;
  logic [DATA_W-1:0] misr_sig;

  assign busy_w   = (state_q != StIdle) && (state_q != StDone);
  // Signature mode never compares per pattern.
  assign mismatch = (mode_q != ModeSig) && (cap_q != expect_in);

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    limit_d      = limit_q;
    pat_idx_d    = pat_idx_q;
    err_cnt_d    = err_cnt_q;
    first_err_d  = first_err_q;
    pass_d       = pass_q;
    aborted_d    = aborted_q;
    cap_d        = cap_q;
    settle_cnt_d = settle_cnt_q;
    misr_seed    = 1'b0;
    misr_en      = 1'b0;

    if (busy_w && abort) begin
      // Abort preempts whatever the busy state would have done this cycle.
      state_d   = StDone;
      aborted_d = 1'b1;
      pass_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mode_d  = Mode_sel;
            limit_d = pat_limit;
            if (mode_runs(Mode_sel)) begin
              state_d = StLoad;
            end else begin
              // Bypass and unknown modes finish at once without touching the MISR.
              state_d     = StDone;
              pat_idx_d   = '0;
              err_cnt_d   = '0;
              first_err_d = '0;
              aborted_d   = 1'b0;
              pass_d      = (Mode_sel == ModeBypass);
            end
          end
        end
        StLoad: begin
          pat_idx_d   = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          aborted_d   = 1'b0;
          pass_d      = 1'b0;
          misr_seed   = 1'b1;
          state_d     = StApply;
        end
        StApply: begin
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            state_d = StCapture;
          end else begin
            settle_cnt_d = settle_cnt_q + CntW'(1);
          end
        end
        StCapture: begin
          cap_d   = resp_in;
          state_d = StCheck;
        end
        StCheck: begin
          misr_en = 1'b1;
          if (mismatch) begin
            err_cnt_d = err_cnt_q + (PAT_W + 1)'(1);
            if (err_cnt_q == '0) begin
              first_err_d = pat_idx_q;
            end
          end
          if ((mode_q == ModeStopErr) && mismatch) begin
            pass_d  = 1'b0;
            state_d = StDone;
          end else if (pat_idx_q == limit_q) begin
            state_d = StFinish;
          end else begin
            pat_idx_d = pat_idx_q + PAT_W'(1);
            state_d   = StApply;
          end
        end
        StFinish: begin
          pass_d  = (mode_q == ModeSig) ? (misr_sig == expect_in) : (err_cnt_q == '0);
          state_d = StDone;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge BIST_clk) begin
    if (res) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge BIST_clk) begin
    if (res) begin
      mode_q       <= '0;
      limit_q      <= '0;
      pat_idx_q    <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cap_q        <= '0;
      settle_cnt_q <= '0;
    end else begin
      mode_q       <= mode_d;
      limit_q      <= limit_d;
      pat_idx_q    <= pat_idx_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
      pass_q       <= pass_d;
      aborted_q    <= aborted_d;
      cap_q        <= cap_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  bist_misr #(
    .DATA_W    (DATA_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk  (BIST_clk),
    .res  (res),
    .seed (misr_seed),
    .en   (misr_en),
    .din  (cap_q),
    .sig  (misr_sig)
  );

  assign pat_en    = (state_q == StApply);
  assign cap_en    = (state_q == StCapture);
  assign busy      = busy_w;
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign aborted   = aborted_q;
  assign pat_idx   = pat_idx_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign signature = misr_sig;
  assign BIST_CODE = bist_code(state_q);

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Randomised self-checking bench for bist_seq_ctrl against a pattern-level model.
module tb_bist_seq_ctrl;

  localparam int unsigned PAT_W  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SETTLE = 2;
  localparam logic [15:0] POLY   = 16'h1021;
  localparam int          PerPat = SETTLE + 3;

  logic        BIST_clk, res, start, abort;
  logic [3:0]  Mode_sel;
  logic [7:0]  pat_limit;
  logic [15:0] resp_in, expect_in;
  logic        pat_en, cap_en, busy, done, pass, aborted;
  logic [7:0]  pat_idx, first_err;
  logic [8:0]  err_cnt;
  logic [15:0] signature;
  logic [4:0]  BIST_CODE;

  logic [15:0] resp_arr [256];
  logic [15:0] exp_arr  [256];
  logic        sig_mode;
  logic [15:0] golden;

  int checks = 0;
  int errors = 0;

  bist_seq_ctrl #(
    .PAT_W     (PAT_W),
    .DATA_W    (DATA_W),
    .SETTLE    (SETTLE),
    .MISR_POLY (POLY)
  ) dut (
    .BIST_clk  (BIST_clk),
    .res       (res),
    .Mode_sel  (Mode_sel),
    .start     (start),
    .abort     (abort),
    .pat_limit (pat_limit),
    .resp_in   (resp_in),
    .expect_in (expect_in),
    .pat_en    (pat_en),
    .cap_en    (cap_en),
    .pat_idx   (pat_idx),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .aborted   (aborted),
    .err_cnt   (err_cnt),
    .first_err (first_err),
    .signature (signature),
    .BIST_CODE (BIST_CODE)
  );

  // The CUT stand-in answers for whichever pattern the sequencer is on.
  assign resp_in   = resp_arr[pat_idx];
  assign expect_in = sig_mode ? golden : exp_arr[pat_idx];

  initial BIST_clk = 1'b0;
  always #5 BIST_clk = ~BIST_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Random responses; roughly one in err_mod patterns gets a wrong expectation.
  task automatic fill(input int n, input int err_mod);
    for (int i = 0; i < n; i++) begin
      resp_arr[i] = 16'($urandom);
      exp_arr[i]  = resp_arr[i];
      if (err_mod > 0 && $urandom_range(err_mod - 1) == 0)
        exp_arr[i] = exp_arr[i] ^ 16'($urandom_range(65535, 1));
    end
  endtask

  // Pattern-level reference: walks patterns, folds responses, counts mismatches.
  task automatic model_run(input logic [3:0] mode, input int limit,
                           output bit e_pass, output int e_err, output int e_first,
                           output logic [15:0] e_sig, output int e_idx,
                           output int e_cycles, output int e_pulses);
    logic [15:0] sig;
    bit stopped;
    sig = 16'hFFFF;
    e_err = 0; e_first = 0; e_idx = 0; e_pulses = 0; stopped = 0;
    if (!(mode == 4'b0100 || mode == 4'b0101 || mode == 4'b0110)) begin
      e_pass = (mode == 4'b0000);
      e_sig = '0; e_cycles = 0;
      return;
    end
    for (int i = 0; i <= limit; i++) begin
      e_pulses++;
      e_idx = i;
      sig = (sig << 1) ^ (sig[15] ? POLY : 16'h0000) ^ resp_arr[i];
      if (mode != 4'b0110 && resp_arr[i] != exp_arr[i]) begin
        if (e_err == 0) e_first = i;
        e_err++;
        if (mode == 4'b0101) begin
          stopped = 1;
          break;
        end
      end
    end
    e_sig    = sig;
    e_cycles = 1 + e_pulses * PerPat + (stopped ? 0 : 1);
    if (stopped)             e_pass = 0;
    else if (mode == 4'b0110) e_pass = (sig == golden);
    else                     e_pass = (e_err == 0);
  endtask

  // Starts a run and watches it to DONE; cycles = clocks spent before DONE.
  task automatic do_run(input logic [3:0] mode, input int limit, output int cycles,
                        output int pulses, output int caps, output int idx_bad);
    @(negedge BIST_clk);
    Mode_sel  = mode;
    pat_limit = limit[7:0];
    start     = 1'b1;
    @(posedge BIST_clk);
    cycles = 0; pulses = 0; caps = 0; idx_bad = 0;
    @(negedge BIST_clk);
    start = 1'b0;
    while (done !== 1'b1 && cycles < 4000) begin
      if (pat_en === 1'b1) begin
        if (pat_idx !== pulses[7:0]) idx_bad++;
        pulses++;
      end
      if (cap_en === 1'b1) caps++;
      cycles++;
      @(negedge BIST_clk);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(posedge BIST_clk);
    @(negedge BIST_clk);
    checks++;
    if ({pat_en, cap_en, busy, done, pass, aborted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {pat_en, cap_en, busy, done, pass, aborted});
    end
    checks++;
    if ({pat_idx, err_cnt, first_err, signature, BIST_CODE} !== '0) begin
      errors++;
      $display("FAIL reset_values: idx=%0h err=%0h first=%0h sig=%0h code=%0h want all 0",
               pat_idx, err_cnt, first_err, signature, BIST_CODE);
    end
    res = 1'b0;
  endtask

  task automatic test_full_pass();
    int cyc, pul, cap, ib, e_err, e_first, e_idx, e_cyc, e_pul;
    bit e_pass;
    logic [15:0] e_sig;
    fill(4, 0);
    sig_mode = 1'b0;
    model_run(4'b0100, 3, e_pass, e_err, e_first, e_sig, e_idx, e_cyc, e_pul);
    do_run(4'b0100, 3, cyc, pul, cap, ib);
    checks++;
    if (pul !== 4 || cap !== 4 || ib !== 0) begin
      errors++;
      $display("FAIL full_pass_pulses: pat_en=%0d cap_en=%0d bad_idx=%0d want 4 4 0", pul, cap, ib);
    end
    checks++;
    if (cyc !== 22) begin
      errors++;
      $display("FAIL full_pass_latency: got %0d cycles want 22", cyc);
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 9'd0 || pat_idx !== 8'd3) begin
      errors++;
      $display("FAIL full_pass_result: pass=%b err=%0d idx=%0d want 1 0 3", pass, err_cnt, pat_idx);
    end
    checks++;
    if (signature !== e_sig) begin
      errors++;
      $display("FAIL full_pass_sig: got %h want %h", signature, e_sig);
    end
  endtask

  task automatic test_full_errors();
    int cyc, pul, cap, ib, e_err, e_first, e_idx, e_cyc, e_pul;
    bit e_pass;
    logic [15:0] e_sig;
    fill(8, 0);
    exp_arr[2] = exp_arr[2] ^ 16'h0100;
    exp_arr[5] = exp_arr[5] ^ 16'h8001;
    sig_mode = 1'b0;
    model_run(4'b0100, 7, e_pass, e_err, e_first, e_sig, e_idx, e_cyc, e_pul);
    do_run(4'b0100, 7, cyc, pul, cap, ib);
    checks++;
    if (err_cnt !== 9'd2 || first_err !== 8'd2 || pass !== 1'b0) begin
      errors++;
      $display("FAIL full_err_result: err=%0d first=%0d pass=%b want 2 2 0", err_cnt, first_err, pass);
    end
    checks++;
    if (pul !== 8 || cyc !== e_cyc || signature !== e_sig) begin
      errors++;
      $display("FAIL full_err_run: pulses=%0d cyc=%0d sig=%h want 8 %0d %h", pul, cyc, signature,
               e_cyc, e_sig);
    end

    // Same stimulus, stop-on-first-error mode.
    model_run(4'b0101, 7, e_pass, e_err, e_first, e_sig, e_idx, e_cyc, e_pul);
    do_run(4'b0101, 7, cyc, pul, cap, ib);
    checks++;
    if (pat_idx !== 8'd2 || pass !== 1'b0 || err_cnt !== 9'd1 || first_err !== 8'd2) begin
      errors++;
      $display("FAIL stop_err_result: idx=%0d pass=%b err=%0d first=%0d want 2 0 1 2",
               pat_idx, pass, err_cnt, first_err);
    end
    checks++;
    if (pul !== 3 || cyc !== 16 || signature !== e_sig) begin
      errors++;
      $display("FAIL stop_err_run: pulses=%0d cyc=%0d sig=%h want 3 16 %h", pul, cyc, signature, e_sig);
    end
  endtask

  task automatic test_signature();
    int cyc, pul, cap, ib;
    resp_arr[0] = 16'h0000;
    exp_arr[0]  = 16'h1234;
    sig_mode    = 1'b1;
    golden      = 16'hEFDF;
    do_run(4'b0110, 0, cyc, pul, cap, ib);
    checks++;
    if (signature !== 16'hEFDF || pass !== 1'b1 || err_cnt !== 9'd0) begin
      errors++;
      $display("FAIL sig_good: sig=%h pass=%b err=%0d want efdf 1 0", signature, pass, err_cnt);
    end
    golden = 16'h0000;
    do_run(4'b0110, 0, cyc, pul, cap, ib);
    checks++;
    if (signature !== 16'hEFDF || pass !== 1'b0) begin
      errors++;
      $display("FAIL sig_bad: sig=%h pass=%b want efdf 0", signature, pass);
    end
    sig_mode = 1'b0;
  endtask

  task automatic test_abort();
    int k;
    fill(4, 0);
    sig_mode = 1'b0;
    @(negedge BIST_clk);
    Mode_sel = 4'b0100; pat_limit = 8'd3; start = 1'b1;
    @(negedge BIST_clk);
    start = 1'b0;
    k = 0;
    while (!(BIST_CODE === 5'd3 && pat_idx === 8'd1) && k < 100) begin
      @(negedge BIST_clk);
      k++;
    end
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL abort_reach_settle: code=%0d idx=%0d never reached 3/1", BIST_CODE, pat_idx);
    end
    abort = 1'b1;
    @(negedge BIST_clk);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || pass !== 1'b0 || busy !== 1'b0 || BIST_CODE !== 5'd7) begin
      errors++;
      $display("FAIL abort_done: done=%b aborted=%b pass=%b busy=%b code=%0d want 1 1 0 0 7",
               done, aborted, pass, busy, BIST_CODE);
    end
    abort = 1'b1;
    @(negedge BIST_clk);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || BIST_CODE !== 5'd7) begin
      errors++;
      $display("FAIL abort_in_done: done=%b aborted=%b code=%0d want 1 1 7", done, aborted, BIST_CODE);
    end
  endtask

  task automatic test_reset_midrun();
    fill(4, 2);
    @(negedge BIST_clk);
    Mode_sel = 4'b0100; pat_limit = 8'd3; start = 1'b1;
    @(negedge BIST_clk);
    start = 1'b0;
    repeat (9) @(negedge BIST_clk);
    res = 1'b1;
    @(negedge BIST_clk);
    res = 1'b0;
    checks++;
    if ({pat_en, cap_en, busy, done, pass, aborted} !== 6'b0 ||
        {pat_idx, err_cnt, first_err, signature, BIST_CODE} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: flags=%b idx=%0h err=%0h first=%0h sig=%h code=%0d want all 0",
               {pat_en, cap_en, busy, done, pass, aborted}, pat_idx, err_cnt, first_err,
               signature, BIST_CODE);
    end
    @(negedge BIST_clk);
    checks++;
    if (BIST_CODE !== 5'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: code=%0d done=%b want 0 0", BIST_CODE, done);
    end
  endtask

  task automatic test_bad_mode();
    int cyc, pul, cap, ib;
    do_run(4'b1111, 5, cyc, pul, cap, ib);
    checks++;
    if (cyc !== 0 || done !== 1'b1 || pass !== 1'b0 || pul !== 0) begin
      errors++;
      $display("FAIL bad_mode: cyc=%0d done=%b pass=%b pulses=%0d want 0 1 0 0", cyc, done, pass, pul);
    end
    do_run(4'b0000, 5, cyc, pul, cap, ib);
    checks++;
    if (cyc !== 0 || done !== 1'b1 || pass !== 1'b1 || pul !== 0) begin
      errors++;
      $display("FAIL bypass_mode: cyc=%0d done=%b pass=%b pulses=%0d want 0 1 1 0", cyc, done, pass, pul);
    end
  endtask

  task automatic test_full_length();
    int cyc, pul, cap, ib, e_err, e_first, e_idx, e_cyc, e_pul;
    bit e_pass;
    logic [15:0] e_sig;
    fill(256, 16);
    sig_mode = 1'b0;
    model_run(4'b0100, 255, e_pass, e_err, e_first, e_sig, e_idx, e_cyc, e_pul);
    do_run(4'b0100, 255, cyc, pul, cap, ib);
    checks++;
    if (pul !== 256 || pat_idx !== 8'd255 || ib !== 0 || cyc !== 1282) begin
      errors++;
      $display("FAIL full_length_run: pulses=%0d idx=%0d bad_idx=%0d cyc=%0d want 256 255 0 1282",
               pul, pat_idx, ib, cyc);
    end
    checks++;
    if (err_cnt !== 9'(e_err) || first_err !== 8'(e_first) || pass !== e_pass ||
        signature !== e_sig) begin
      errors++;
      $display("FAIL full_length_result: err=%0d first=%0d pass=%b sig=%h want %0d %0d %b %h",
               err_cnt, first_err, pass, signature, e_err, e_first, e_pass, e_sig);
    end
  endtask

  // Consecutive random runs, each started straight out of the previous DONE.
  task automatic test_back_to_back();
    int cyc, pul, cap, ib, e_err, e_first, e_idx, e_cyc, e_pul, lim;
    bit e_pass, run_mode;
    logic [15:0] e_sig;
    logic [3:0] mode;
    logic [3:0] modes [5];
    modes[0] = 4'b0100; modes[1] = 4'b0101; modes[2] = 4'b0110; modes[3] = 4'b0000;
    for (int it = 0; it < 24; it++) begin
      modes[4] = 4'($urandom);
      mode = modes[$urandom_range(4)];
      lim  = $urandom_range(15);
      fill(lim + 1, 4);
      sig_mode = (mode == 4'b0110);
      golden   = 16'($urandom);
      model_run(mode, lim, e_pass, e_err, e_first, e_sig, e_idx, e_cyc, e_pul);
      if ($urandom_range(1) == 1) golden = e_sig;
      model_run(mode, lim, e_pass, e_err, e_first, e_sig, e_idx, e_cyc, e_pul);
      run_mode = (mode == 4'b0100 || mode == 4'b0101 || mode == 4'b0110);
      do_run(mode, lim, cyc, pul, cap, ib);
      checks++;
      if (done !== 1'b1 || cyc !== e_cyc || pul !== e_pul || cap !== e_pul || ib !== 0) begin
        errors++;
        $display("FAIL b2b_timing[%0d] mode=%b lim=%0d: done=%b cyc=%0d pulses=%0d caps=%0d bad=%0d want 1 %0d %0d",
                 it, mode, lim, done, cyc, pul, cap, ib, e_cyc, e_pul);
      end
      checks++;
      if (pass !== e_pass || err_cnt !== 9'(e_err) || first_err !== 8'(e_first) ||
          pat_idx !== 8'(e_idx) || aborted !== 1'b0) begin
        errors++;
        $display("FAIL b2b_result[%0d] mode=%b: pass=%b err=%0d first=%0d idx=%0d ab=%b want %b %0d %0d %0d 0",
                 it, mode, pass, err_cnt, first_err, pat_idx, aborted, e_pass, e_err, e_first, e_idx);
      end
      if (run_mode) begin
        checks++;
        if (signature !== e_sig) begin
          errors++;
          $display("FAIL b2b_sig[%0d]: got %h want %h", it, signature, e_sig);
        end
      end
    end
    sig_mode = 1'b0;
  endtask

  initial begin
    res = 1'b1; start = 1'b0; abort = 1'b0; Mode_sel = 4'b0000; pat_limit = 8'd0;
    sig_mode = 1'b0; golden = 16'h0000;
    fill(256, 0);
    test_reset();
    test_full_pass();
    test_full_errors();
    test_signature();
    test_abort();
    test_reset_midrun();
    test_bad_mode();
    test_full_length();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
